// File: rtl/trace_capture_fifo.sv
// Show-ahead trace FIFO capturing register-file writebacks from cpu_core.
// Define TRACE_FILTER_R0_EN to ignore writes addressed to register 0.
module trace_capture_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset_,
  input  logic [31:0]              debug_program_count,
  input  logic [3:0]               debug_register_file_write_enabled,
  input  logic [4:0]               debug_register_file_write_address,
  input  logic [31:0]              debug_register_file_write_data,
  input  logic                     clear,
  output logic                     trace_valid,
  input  logic                     trace_ready,
  output logic [31:0]              trace_program_count,
  output logic [3:0]               trace_write_enabled,
  output logic [4:0]               trace_write_address,
  output logic [31:0]              trace_write_data,
  output logic [$clog2(DEPTH):0]   trace_count,
  output logic [15:0]              overflow_count
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = 73;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [ENTRY_W-1:0] head;

  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [15:0]      ovf_reg, ovf_next;

  logic capture, full, pop, push, drop;

`ifdef TRACE_FILTER_R0_EN
  assign capture = (debug_register_file_write_enabled != 4'b0000) &&
                   (debug_register_file_write_address != 5'd0);
`else
  assign capture = (debug_register_file_write_enabled != 4'b0000);
`endif

  assign full        = (count_reg == CNT_W'(DEPTH));
  assign trace_valid = (count_reg != '0);
  assign pop         = trace_valid && trace_ready;
  // A pop frees the slot at the same edge, so a full FIFO can still accept.
  assign push        = capture && (!full || pop);
  assign drop        = capture && full && !pop;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    ovf_next    = ovf_reg;
    if (clear) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
      ovf_next    = '0;
    end else begin
      if (push) wr_ptr_next = wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_next = rd_ptr_reg + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_next = count_reg + CNT_W'(1);
        2'b01:   count_next = count_reg - CNT_W'(1);
        default: count_next = count_reg;
      endcase
      if (drop && ovf_reg != 16'hFFFF) ovf_next = ovf_reg + 16'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      ovf_reg    <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      ovf_reg    <= ovf_next;
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clock) begin
    if (push && !clear) begin
      mem[wr_ptr_reg] <= {debug_program_count,
                          debug_register_file_write_enabled,
                          debug_register_file_write_address,
                          debug_register_file_write_data};
    end
  end

  assign head = mem[rd_ptr_reg];

  assign trace_program_count = trace_valid ? head[72:41] : 32'd0;
  assign trace_write_enabled = trace_valid ? head[40:37] : 4'd0;
  assign trace_write_address = trace_valid ? head[36:32] : 5'd0;
  assign trace_write_data    = trace_valid ? head[31:0]  : 32'd0;
  assign trace_count         = count_reg;
  assign overflow_count      = ovf_reg;

endmodule

// File: doc/trace_capture_fifo.md
TRACE_CAPTURE_FIFO -- requirements
Module: trace_capture_fifo

Interface
REQ-001 SHALL provide parameter: DEPTH, 16, number of trace entries stored; power of two, 2 to 256.
REQ-002 SHALL provide port: clock  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL provide port: reset_  input  1  asynchronous, active-low reset.
REQ-004 SHALL provide port: debug_program_count  input  32  writeback-stage PC from cpu_core.
REQ-005 SHALL provide port: debug_register_file_write_enabled  input  4  per-byte register write enable from cpu_core.
REQ-006 SHALL provide port: debug_register_file_write_address  input  5  destination register from cpu_core.
REQ-007 SHALL provide port: debug_register_file_write_data  input  32  write data from cpu_core.
REQ-008 SHALL provide port: clear  input  1  synchronous flush of FIFO contents and overflow counter.
REQ-009 SHALL provide port: trace_valid  output  1  head entry available.
REQ-010 SHALL provide port: trace_ready  input  1  consumer accepts head entry.
REQ-011 SHALL provide port: trace_program_count  output  32  head entry PC.
REQ-012 SHALL provide port: trace_write_enabled  output  4  head entry byte enables.
REQ-013 SHALL provide port: trace_write_address  output  5  head entry register address.
REQ-014 SHALL provide port: trace_write_data  output  32  head entry data.
REQ-015 SHALL provide port: trace_count  output  clog2(DEPTH)+1  entries currently stored.
REQ-016 SHALL provide port: overflow_count  output  16  entries dropped because FIFO full.

Function
REQ-017 SHALL treat a cycle as a capture event when debug_register_file_write_enabled != 4'b0000.
REQ-018 SHALL write the 73-bit entry {PC, enables, address, data} of a capture event into the tail slot at that rising edge.
REQ-019 SHALL present the head entry on trace_* outputs show-ahead; an event captured at edge N into an empty FIFO is visible with trace_valid=1 after edge N.
REQ-020 SHALL drive trace_valid = (trace_count != 0).
REQ-021 SHALL pop the head at an edge where trace_valid && trace_ready.
REQ-022 SHALL hold all trace_* outputs stable while trace_valid && !trace_ready.
REQ-023 SHALL wrap read and write pointers modulo DEPTH.
REQ-024 SHALL, when full with capture and pop at the same edge, accept the capture and keep trace_count = DEPTH.
REQ-025 SHALL, when full with capture and no pop, drop the entry and increment overflow_count, saturating at 16'hFFFF.
REQ-026 SHALL, when empty with capture and trace_ready=1 at the same edge, store the entry (no bypass; it appears after the edge).
REQ-027 SHALL, on clear=1, set trace_count=0, reset both pointers, zero overflow_count, and discard any same-cycle capture and pop.
REQ-028 SHALL update trace_count by +1 (push only), -1 (pop only), or 0 (both or neither).
REQ-029 SHALL ignore trace_ready when trace_valid=0.

Reset
REQ-030 SHALL, while reset_=0, asynchronously force trace_count=0, overflow_count=0, both pointers to 0, and trace_valid=0.
REQ-031 SHALL drive trace_program_count, trace_write_enabled, trace_write_address and trace_write_data to 0 while trace_valid=0.
REQ-032 SHALL discard in-flight entries on reset mid-operation; storage array contents need no reset.

Configuration
REQ-033 SHALL, with TRACE_FILTER_R0_EN defined, exclude writes with debug_register_file_write_address == 0 from capture events (no store, no overflow increment).
REQ-034 SHALL, without TRACE_FILTER_R0_EN, capture writes to register 0 like any other address.

Verification
REQ-035 SHALL cover: one capture {PC=0xBFC00000, en=4'hF, addr=5, data=0x1234} with ready=0 -> next cycle trace_valid=1, outputs match, count=1; outputs stable for 3 cycles; ready=1 -> count=0.
REQ-036 SHALL cover: DEPTH=16, 20 consecutive captures, ready=0 -> count=16, overflow_count=4, head PC equals first captured PC.
REQ-037 SHALL cover: full FIFO, capture with ready=1 -> count stays 16, overflow_count unchanged, new entry emerges 16th after.
REQ-038 SHALL cover: 40 pushes/pops with ready toggling every cycle -> output sequence equals input order across pointer wrap.
REQ-039 SHALL cover: clear=1 coincident with capture at count=5, overflow_count=2 -> count=0, overflow_count=0, trace_valid=0 next cycle.
REQ-040 SHALL cover: capture to addr=0 -> count=1 without TRACE_FILTER_R0_EN, count=0 with it; reset_ pulse at count=7 -> count=0 immediately.
